// File: rtl/hdlc_tx_framer_if.sv
// hdlc_tx_framer_if: Tx buffer handshake, control and serial-line bundle between the framer and its client
interface hdlc_tx_framer_if;
    logic       Tx_Enable;
    logic       Tx_AbortFrame;
    logic [7:0] Tx_FrameSize;
    logic       Tx_DataAvail;
    logic [7:0] Tx_Data;
    logic       Tx_RdBuff;
    logic       Tx;
    logic       Tx_ValidFrame;
    logic       Tx_Done;
    logic       Tx_AbortedTrans;
    modport master(
        output Tx_Enable, Tx_AbortFrame, Tx_FrameSize, Tx_DataAvail, Tx_Data,
        input  Tx_RdBuff, Tx, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans
    );
    modport slave(
        input  Tx_Enable, Tx_AbortFrame, Tx_FrameSize, Tx_DataAvail, Tx_Data,
        output Tx_RdBuff, Tx, Tx_ValidFrame, Tx_Done, Tx_AbortedTrans
    );
endinterface

// File: rtl/hdlc_tx_framer.sv
// hdlc_tx_framer: serial HDLC transmitter (flags, zero insertion, CRC-16 FCS, idle and abort patterns)
module hdlc_tx_framer #(
    parameter logic [7:0]  FLAG      = 8'h7E,
    parameter int          MAX_BYTES = 126,
    parameter logic [15:0] FCS_INIT  = 16'hFFFF
) (
    input logic         Clk,
    input logic         Rst,
    hdlc_tx_framer_if.slave txIf
);
    typedef enum logic [2:0] {IDLE, START_FLAG, DATA, FCS, END_FLAG, ABORT} state_t;
    state_t      state, stateNext;
    logic [4:0]  bitCnt, bitCntNext;
    logic [7:0]  byteCnt, byteCntNext, frameSize, frameSizeNext, shiftReg, shiftRegNext;
    logic [15:0] fcs, fcsNext;
    logic [2:0]  ones, onesNext;
    logic        done, doneNext, aborted, abortedNext;
    logic        stuff, dataBit, underrun, rdBuff, tx, sizeOk;

    assign sizeOk = txIf.Tx_FrameSize != 8'd0 && int'(txIf.Tx_FrameSize) <= MAX_BYTES;

    always_comb begin
        stateNext = state;
        bitCntNext = bitCnt;
        byteCntNext = byteCnt;
        frameSizeNext = frameSize;
        shiftRegNext = shiftReg;
        fcsNext = fcs;
        onesNext = ones;
        doneNext = 1'b0;
        abortedNext = aborted;
        underrun = 1'b0;
        rdBuff = 1'b0;
        tx = 1'b1;
        stuff = ones == 3'd5;
        dataBit = state == FCS ? ~fcs[bitCnt[3:0]] : shiftReg[0];
        case (state)
            IDLE: if (txIf.Tx_Enable && sizeOk) begin
                stateNext = START_FLAG;
                frameSizeNext = txIf.Tx_FrameSize;
                abortedNext = 1'b0;
                bitCntNext = '0;
                fcsNext = FCS_INIT;
            end
            START_FLAG, END_FLAG: begin
                tx = FLAG[bitCnt[2:0]];
                bitCntNext = bitCnt + 5'd1;
                if (bitCnt == 5'd7) begin
                    bitCntNext = '0;
                    if (state == END_FLAG) begin
                        stateNext = IDLE;
                        doneNext = 1'b1;
                    end else if (txIf.Tx_DataAvail) begin
                        rdBuff = 1'b1;
                        shiftRegNext = txIf.Tx_Data;
                        byteCntNext = 8'd1;
                        onesNext = '0;
                        stateNext = DATA;
                    end else underrun = 1'b1;
                end
            end
            DATA, FCS: begin
                tx = !stuff && dataBit;
                if (stuff) begin
                    onesNext = '0;
                    if (bitCnt == 5'd16) begin
                        stateNext = END_FLAG;
                        bitCntNext = '0;
                    end
                end else begin
                    onesNext = dataBit ? ones + 3'd1 : 3'd0;
                    bitCntNext = bitCnt + 5'd1;
                    if (state == DATA) begin
                        fcsNext = {1'b0, fcs[15:1]} ^ (fcs[0] ^ dataBit ? 16'h8408 : 16'h0000);
                        shiftRegNext = {1'b0, shiftReg[7:1]};
                        if (bitCnt == 5'd7) begin
                            bitCntNext = '0;
                            if (byteCnt == frameSize) stateNext = FCS;
                            else if (txIf.Tx_DataAvail) begin
                                rdBuff = 1'b1;
                                shiftRegNext = txIf.Tx_Data;
                                byteCntNext = byteCnt + 8'd1;
                            end else underrun = 1'b1;
                        end
                    end else if (bitCnt == 5'd15) begin
                        // a stuff owed after the last FCS bit parks the counter at 16 for one extra cycle
                        if (dataBit && ones == 3'd4) bitCntNext = 5'd16;
                        else begin
                            stateNext = END_FLAG;
                            bitCntNext = '0;
                        end
                    end
                end
            end
            ABORT: begin
                tx = bitCnt != 5'd0;
                bitCntNext = bitCnt + 5'd1;
                if (bitCnt == 5'd7) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
        if (underrun || (txIf.Tx_AbortFrame && (state == START_FLAG || state == DATA || state == FCS))) begin
            stateNext = ABORT;
            bitCntNext = '0;
            abortedNext = 1'b1;
            rdBuff = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
            bitCnt <= '0;
            byteCnt <= '0;
            frameSize <= '0;
            shiftReg <= '0;
            fcs <= FCS_INIT;
            ones <= '0;
            done <= 1'b0;
            aborted <= 1'b0;
        end else begin
            state <= stateNext;
            bitCnt <= bitCntNext;
            byteCnt <= byteCntNext;
            frameSize <= frameSizeNext;
            shiftReg <= shiftRegNext;
            fcs <= fcsNext;
            ones <= onesNext;
            done <= doneNext;
            aborted <= abortedNext;
        end
    end

    assign txIf.Tx = tx;
    assign txIf.Tx_RdBuff = rdBuff && !Rst;
    assign txIf.Tx_ValidFrame = state inside {START_FLAG, DATA, FCS, END_FLAG};
    assign txIf.Tx_Done = done;
    assign txIf.Tx_AbortedTrans = aborted;
endmodule

// File: tb/tb_hdlc_tx_framer.sv
// tb_hdlc_tx_framer: randomized frames checked against a bit-level HDLC model and an Rx-side unstuff/CRC check
module tb_hdlc_tx_framer;
    localparam logic [7:0] FLAG_B = 8'h7E;
    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int nTests = 0;
    int nFail = 0;
    logic [7:0] dataQ[$];
    logic expS[$];
    int expLast[$];
    logic trTx[$], trValid[$], trDone[$], trAbt[$];
    int rdCount;

    always #5 Clk = ~Clk;

    hdlc_tx_framer_if txIf();
    hdlc_tx_framer dut(.Clk(Clk), .Rst(Rst), .txIf(txIf));

    function automatic logic [15:0] crc_bits(input logic b[$]);
        logic [15:0] c = 16'hFFFF;
        foreach (b[i]) c = (c >> 1) ^ ((c[0] ^ b[i]) ? 16'h8408 : 16'h0000);
        return c;
    endfunction

    // Expected line bits: flag, stuffed (data + ~CRC), flag; also where each non-final byte ends
    function automatic void build(input logic [7:0] d[$]);
        logic raw[$];
        logic [15:0] f;
        int ones = 0;
        expS.delete();
        expLast.delete();
        foreach (d[k]) for (int b = 0; b < 8; b++) raw.push_back(d[k][b]);
        f = ~crc_bits(raw);
        for (int b = 0; b < 16; b++) raw.push_back(f[b]);
        for (int b = 0; b < 8; b++) expS.push_back(FLAG_B[b]);
        foreach (raw[i]) begin
            expS.push_back(raw[i]);
            ones = raw[i] ? ones + 1 : 0;
            if (i % 8 == 7 && i < 8 * (d.size() - 1)) expLast.push_back(expS.size() - 1);
            if (ones == 5) begin
                expS.push_back(1'b0);
                ones = 0;
            end
        end
        for (int b = 0; b < 8; b++) expS.push_back(FLAG_B[b]);
    endfunction

    function automatic void fill(input int n);
        dataQ.delete();
        for (int i = 0; i < n; i++) dataQ.push_back($urandom_range(0, 3) == 0 ? 8'hFF : 8'($urandom));
    endfunction

    task automatic run_frame(input int size, input int abortAt, input int popLimit, input int rstAt, input int cycles);
        int pops = 0;
        logic popPending = 1'b0;
        trTx.delete(); trValid.delete(); trDone.delete(); trAbt.delete();
        rdCount = 0;
        txIf.Tx_Enable = 1'b1;
        txIf.Tx_FrameSize = size[7:0];
        txIf.Tx_DataAvail = dataQ.size() > 0;
        txIf.Tx_Data = dataQ.size() > 0 ? dataQ[0] : 8'h00;
        for (int i = 0; i < cycles; i++) begin
            @(posedge Clk); #1;
            if (popPending) begin
                void'(dataQ.pop_front());
                pops++;
                popPending = 1'b0;
            end
            txIf.Tx_Enable = 1'b0;
            trTx.push_back(txIf.Tx);
            trValid.push_back(txIf.Tx_ValidFrame);
            trDone.push_back(txIf.Tx_Done);
            trAbt.push_back(txIf.Tx_AbortedTrans);
            Rst = i == rstAt;
            txIf.Tx_AbortFrame = i == abortAt;
            txIf.Tx_DataAvail = dataQ.size() > 0 && pops < popLimit;
            txIf.Tx_Data = dataQ.size() > 0 ? dataQ[0] : 8'h00;
            #1;
            if (txIf.Tx_RdBuff === 1'b1) begin
                rdCount++;
                popPending = 1'b1;
            end
        end
        Rst = 1'b0;
        txIf.Tx_AbortFrame = 1'b0;
    endtask

    task automatic test_reset();
        txIf.Tx_Enable = 1'b0;
        txIf.Tx_AbortFrame = 1'b0;
        txIf.Tx_FrameSize = 8'd0;
        txIf.Tx_DataAvail = 1'b1;
        txIf.Tx_Data = 8'hA5;
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge Clk); #1;
            nTests++;
            if ({txIf.Tx, txIf.Tx_ValidFrame, txIf.Tx_RdBuff, txIf.Tx_Done, txIf.Tx_AbortedTrans} !== 5'b10000) begin
                nFail++;
                $display("FAIL reset idle cycle %0d: Tx/Valid/Rd/Done/Abt=%b%b%b%b%b want 10000", i,
                         txIf.Tx, txIf.Tx_ValidFrame, txIf.Tx_RdBuff, txIf.Tx_Done, txIf.Tx_AbortedTrans);
            end
        end
    endtask

    task automatic test_normal_frame(input string name);
        logic [7:0] sent[$] = dataQ;
        logic rx[$];
        int n = sent.size();
        int len, bad = -1, vcnt = 0, dcnt = 0, donePos = -1, acnt = 0, ones = 0;
        logic [15:0] res;
        logic dataOk = 1'b1;
        build(sent);
        len = expS.size();
        run_frame(n, -1, 1000, -1, len + 12);
        for (int i = 0; i < len + 12; i++) begin
            if (trTx[i] !== (i < len ? expS[i] : 1'b1) && bad < 0) bad = i;
            if (trValid[i] === 1'b1) vcnt++;
            if (trDone[i] === 1'b1) begin dcnt++; donePos = i; end
            if (trAbt[i] !== 1'b0) acnt++;
        end
        nTests++;
        if (bad >= 0) begin
            nFail++;
            $display("FAIL %s tx stream: bit %0d got %b want %b", name, bad, trTx[bad], bad < len ? expS[bad] : 1'b1);
        end
        nTests++;
        if (vcnt != len || trValid[len - 1] !== 1'b1 || trValid[len] !== 1'b0) begin
            nFail++;
            $display("FAIL %s valid window: %0d cycles, want %0d ending at %0d", name, vcnt, len, len - 1);
        end
        nTests++;
        if (dcnt != 1 || donePos != len) begin
            nFail++;
            $display("FAIL %s done: %0d pulses at %0d, want 1 at %0d", name, dcnt, donePos, len);
        end
        nTests++;
        if (rdCount != n) begin
            nFail++;
            $display("FAIL %s rdbuff count: got %0d want %0d", name, rdCount, n);
        end
        nTests++;
        if (acnt != 0) begin
            nFail++;
            $display("FAIL %s aborted flag: high %0d cycles want 0", name, acnt);
        end
        // Receiver view: strip flags, drop the 0 after five 1s, then check payload and FCS residue
        for (int i = 8; i < vcnt - 8; i++) begin
            if (ones == 5) begin
                ones = 0;
                continue;
            end
            rx.push_back(trTx[i]);
            ones = trTx[i] ? ones + 1 : 0;
        end
        res = crc_bits(rx);
        nTests++;
        if (rx.size() != 8 * (n + 2) || res !== 16'hF0B8) begin
            nFail++;
            $display("FAIL %s rx crc: %0d bits residue %h, want %0d bits residue f0b8", name, rx.size(), res, 8 * (n + 2));
        end
        for (int i = 0; i < 8 * n && i < rx.size(); i++) if (rx[i] !== sent[i / 8][i % 8]) dataOk = 1'b0;
        nTests++;
        if (!dataOk || rx.size() < 8 * n) begin
            nFail++;
            $display("FAIL %s rx data: unstuffed payload differs from %0d sent bytes", name, n);
        end
    endtask

    task automatic test_stuffing();
        logic [8:0] got;
        logic [8:0] want = 9'b111011111;
        dataQ.delete();
        dataQ.push_back(8'hFF);
        test_normal_frame("ones_byte");
        for (int k = 0; k < 9; k++) got[k] = trTx[8 + k];
        nTests++;
        if (got !== want) begin
            nFail++;
            $display("FAIL ones_byte data bits: got %b want %b (bit0 rightmost)", got, want);
        end
    endtask

    // mode 0: abort in byte 2; mode 1: abort on the pop cycle of byte 1; mode 2: underrun before byte 3
    task automatic test_abort(input string name, input int mode);
        logic [7:0] sent[$];
        int size = mode == 0 ? 4 : 3;
        int cut, len, bad = -1, vbad = -1, abad = -1, dcnt = 0, expRd;
        logic e;
        fill(size);
        sent = dataQ;
        build(sent);
        cut = mode == 0 ? 18 : mode == 1 ? expLast[0] : expLast[1];
        expRd = mode == 1 ? 1 : 2;
        len = cut + 22;
        run_frame(size, mode == 2 ? -1 : cut, mode == 2 ? 2 : 1000, -1, len);
        for (int i = 0; i < len; i++) begin
            e = i <= cut ? expS[i] : i != cut + 1;
            if (trTx[i] !== e && bad < 0) bad = i;
            if (trValid[i] !== (i <= cut) && vbad < 0) vbad = i;
            if (trAbt[i] !== (i > cut) && abad < 0) abad = i;
            if (trDone[i] === 1'b1) dcnt++;
        end
        nTests++;
        if (bad >= 0) begin
            nFail++;
            $display("FAIL %s tx pattern: bit %0d got %b want %b", name, bad, trTx[bad], bad <= cut ? expS[bad] : bad != cut + 1);
        end
        nTests++;
        if (vbad >= 0) begin
            nFail++;
            $display("FAIL %s valid: cycle %0d got %b, want low from %0d", name, vbad, trValid[vbad], cut + 1);
        end
        nTests++;
        if (abad >= 0) begin
            nFail++;
            $display("FAIL %s aborted flag: cycle %0d got %b, want high from %0d", name, abad, trAbt[abad], cut + 1);
        end
        nTests++;
        if (dcnt != 0 || rdCount != expRd) begin
            nFail++;
            $display("FAIL %s done/rdbuff: done %0d rd %0d, want done 0 rd %0d", name, dcnt, rdCount, expRd);
        end
        if (mode == 0) begin
            Rst = 1'b1;
            @(posedge Clk); #1;
            Rst = 1'b0;
            nTests++;
            if (txIf.Tx_AbortedTrans !== 1'b0) begin
                nFail++;
                $display("FAIL %s rst clears aborted: got %b want 0", name, txIf.Tx_AbortedTrans);
            end
        end
    endtask

    task automatic test_ignored();
        int sizes[3] = '{0, 127, 200};
        int bad;
        foreach (sizes[k]) begin
            fill(4);
            bad = 0;
            run_frame(sizes[k], -1, 1000, -1, 12);
            foreach (trTx[i]) if (trTx[i] !== 1'b1 || trValid[i] !== 1'b0 || trDone[i] !== 1'b0) bad++;
            nTests++;
            if (bad != 0 || rdCount != 0) begin
                nFail++;
                $display("FAIL ignored size %0d: %0d non-idle cycles, rd %0d, want 0 and 0", sizes[k], bad, rdCount);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int bad = 0;
        fill(4);
        run_frame(4, -1, 1000, 12, 20);
        for (int i = 13; i < 20; i++)
            if ({trTx[i], trValid[i], trDone[i], trAbt[i]} !== 4'b1000) bad++;
        nTests++;
        if (bad != 0 || rdCount != 1) begin
            nFail++;
            $display("FAIL reset mid-data: %0d non-reset cycles, rd %0d, want 0 and 1", bad, rdCount);
        end
    endtask

    initial begin
        test_reset();
        dataQ.delete();
        dataQ.push_back(8'h00);
        test_normal_frame("zero_byte");
        test_stuffing();
        test_abort("abort_byte2", 0);
        test_abort("abort_vs_rdbuff", 1);
        test_abort("underrun", 2);
        fill(5);
        test_normal_frame("after_underrun");
        test_ignored();
        test_reset_mid_frame();
        for (int k = 0; k < 5; k++) begin
            fill($urandom_range(1, 16));
            test_normal_frame($sformatf("random_%0d", k));
        end
        fill(126);
        test_normal_frame("max_size");
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule

// File: doc/hdlc_tx_framer.md
Name: hdlc_tx_framer

Overview:
- Serial HDLC transmit framer, the transmit-side counterpart to the Rx path.
- Pulls bytes from the Tx buffer and emits one bit per Clk on Tx.
- Each frame is sent as: opening flag, LSB-first data with zero insertion, CRC-16 FCS, closing flag.
- Also generates the idle pattern (all ones) and the abort pattern, and drives the Tx status signals Tx_ValidFrame, Tx_Done, Tx_AbortedTrans and Tx_RdBuff.

Parameters:
- FLAG, 8'h7E, opening/closing flag byte.
- MAX_BYTES, 126, largest accepted Tx_FrameSize.
- FCS_INIT, 16'hFFFF, CRC register initial value.

Ports:
- Clk  in  1  clock; one serial bit per rising edge.
- Rst  in  1  synchronous reset, active-high.
- Tx_Enable  in  1  start request, sampled only in IDLE.
- Tx_AbortFrame  in  1  abort request.
- Tx_FrameSize  in  8  byte count, latched at start.
- Tx_DataAvail  in  1  buffer holds a byte.
- Tx_Data  in  8  buffer head byte; valid while Tx_DataAvail is high.
- Tx_RdBuff  out  1  one-cycle pop strobe; Tx_Data is sampled in the same cycle.
- Tx  out  1  serial line.
- Tx_ValidFrame  out  1  high from the first opening-flag bit through the last closing-flag bit.
- Tx_Done  out  1  one-cycle pulse when a frame completes normally.
- Tx_AbortedTrans  out  1  sticky abort indication.

Behaviour:
- Clocking and reset
  - Single clock domain; reset is synchronous and active-high.
  - Rst, including mid-frame, forces on the next edge: state IDLE, Tx=1, Tx_ValidFrame=0, Tx_Done=0, Tx_RdBuff=0, Tx_AbortedTrans=0, FCS=FCS_INIT, ones counter=0, byte counter=0.
- States: IDLE, START_FLAG, DATA, FCS, END_FLAG, ABORT.
- IDLE
  - Tx=1 continuously.
  - Start condition: Tx_Enable=1 and 1<=Tx_FrameSize<=MAX_BYTES. Tx_FrameSize is latched, Tx_AbortedTrans is cleared, and the state goes to START_FLAG.
  - If Tx_FrameSize=0 or Tx_FrameSize>MAX_BYTES, the request is ignored.
  - The first flag bit appears on Tx exactly 1 cycle after Tx_Enable is sampled.
- START_FLAG / END_FLAG
  - Shift FLAG out LSB-first (0,1,1,1,1,1,1,0), 8 cycles, no zero insertion.
  - In the last START_FLAG cycle: Tx_RdBuff=1 if Tx_DataAvail=1. The byte is loaded so the first data bit follows with no gap.
  - If Tx_DataAvail=0 at that point, it is an underrun; handled as an abort (see Abort).
- DATA
  - Each byte goes out LSB-first.
  - Each transmitted data bit (stuffed zeros excluded) updates the FCS. Polynomial x^16+x^12+x^5+1, reflected, LSB-in.
  - On the last bit of byte k < FrameSize: Tx_RdBuff pulses and the next byte is loaded. Tx_DataAvail=0 at that point is an underrun, handled as an abort.
  - After byte FrameSize, go to FCS. Tx_RdBuff pulses exactly FrameSize times per frame.
- FCS
  - Transmit ~FCS, 16 bits, bit 0 first; zero insertion applies.
- Zero insertion
  - The ones counter counts consecutive 1s sent in DATA/FCS.
  - After a fifth consecutive 1, the next cycle sends a stuffed 0. The shift register, FCS and bit counters are held for that cycle, and the ones counter clears.
  - The counter also clears on any data/FCS 0 and on entry to DATA.
  - Stuffing continues across DATA→FCS, and a pending stuff after the final FCS bit is sent before END_FLAG.
- END_FLAG exit
  - After the 8th flag bit: next cycle Tx_Done=1 for one cycle, Tx_ValidFrame=0, state IDLE, Tx=1.
- Abort
  - Tx_AbortFrame=1 in START_FLAG, DATA or FCS (or an underrun) causes, on the next cycle:
    - state ABORT, Tx_ValidFrame=0, Tx_AbortedTrans=1.
    - Tx_RdBuff is suppressed.
    - Tx emits 0 then seven 1s (8 cycles), then IDLE.
  - Tx_Done is not asserted on abort.
  - Tx_AbortFrame in IDLE, END_FLAG or ABORT is ignored.
  - Tx_AbortedTrans stays high until the next accepted start or Rst.
- Simultaneous events
  - Tx_Enable while not IDLE is ignored.
  - Abort takes priority over Tx_RdBuff in the same cycle.

Test Plan:
- Reset, Tx_Enable=0 for 20 cycles → Tx=1, Tx_ValidFrame=0, no Tx_RdBuff.
- FrameSize=1, Data=8'h00 → Tx: 0111_1110, then 0000_0000, then 16 FCS bits equal to the software CRC model (stuffed), then 0111_1110. Tx_RdBuff pulses once, Tx_Done pulses once, 1 cycle after the last flag bit.
- FrameSize=1, Data=8'hFF → data bits on Tx are 1,1,1,1,1,0,1,1,1. The 0 is stuffed and does not enter the FCS. A bench-side Rx-model unstuff and CRC check passes.
- FrameSize=4, Tx_AbortFrame pulsed during byte 2 → next cycle: Tx_ValidFrame=0, Tx=0 then seven 1s. Tx_AbortedTrans=1, no Tx_Done, Tx_RdBuff count=2. Idle ones follow.
- FrameSize=3 with Tx_DataAvail dropped before byte 3 → underrun abort pattern, Tx_AbortedTrans=1. A following Tx_Enable clears it.
- FrameSize=0 or 127 → ignored. Rst asserted mid-DATA → next cycle Tx=1, all outputs at reset values.
